// File: rtl/pc_fetch_ctrl_rv32i_if.sv
// Instruction-fetch bus between the PC/fetch controller and instruction memory.
// The controller drives the address and request; memory answers with an ack.
interface pc_fetch_ctrl_rv32i_if;
  logic [31:0] PCold;
  logic        imem_req;
  logic        imem_ack;
  logic        instr_valid;

  modport master (output PCold, output imem_req, output instr_valid, input imem_ack);
  modport slave  (input PCold, input imem_req, input instr_valid, output imem_ack);
endinterface

// File: rtl/pc_fetch_ctrl_rv32i.sv
// RV32I program counter with next-PC selection and req/ack fetch sequencing.
// Optional feature: define MISALIGN_TRAP_EN to redirect misaligned targets to TRAP_VECTOR.
module pc_fetch_ctrl_rv32i #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
`ifdef MISALIGN_TRAP_EN
  , parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] PC_4_inc,
  input  logic [1:0]  pc_src,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] jalr_base,
  input  logic [31:0] jalr_imm,
  input  logic        stall,
  input  logic        halt,
  input  logic        resume,
  pc_fetch_ctrl_rv32i_if.master bus,
  output logic        halted,
  output logic        misalign
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] jalr_sum;
  logic [31:0] next_pc;
  logic        accept;

  assign jalr_sum = jalr_base + jalr_imm;

  always_comb begin
    unique case (pc_src)
      2'b00:   next_pc = PC_4_inc;
      2'b01:   next_pc = br_taken ? br_target : PC_4_inc;
      2'b10:   next_pc = br_target;
      default: next_pc = {jalr_sum[31:1], 1'b0};
    endcase
  end

  // A fetch completes only when memory acks an unstalled request.
  assign accept = (state == ST_FETCH) && !stall && bus.imem_ack;

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_d         = state;
    pc_d            = pc_q;
    bus.imem_req    = 1'b0;
    bus.instr_valid = 1'b0;
    halted          = 1'b0;
    misalign        = 1'b0;

    unique case (state)
      ST_BOOT: state_d = ST_FETCH;

      ST_FETCH: begin
        if (!stall) begin
          bus.imem_req = 1'b1;
          if (accept) begin
            bus.instr_valid = 1'b1;
`ifdef MISALIGN_TRAP_EN
            if (next_pc[1:0] != 2'b00) begin
              pc_d     = TRAP_VECTOR;
              misalign = 1'b1;
            end else begin
              pc_d = next_pc;
            end
`else
            pc_d = next_pc;
`endif
          end
          // Halt takes effect after any fetch completing in the same cycle.
          if (halt) state_d = ST_HALT;
        end
      end

      ST_HALT: begin
        halted = 1'b1;
        if (!stall && resume && !halt) state_d = ST_FETCH;
      end

      default: state_d = ST_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_BOOT;
      pc_q  <= RESET_VECTOR;
    end else begin
      state <= state_d;
      pc_q  <= pc_d;
    end
  end

  assign bus.PCold = pc_q;

endmodule
